// File: rtl/ctrl_fsm.sv
// Multicycle RV32I control unit: streams boot words into memory after reset,
// then sequences fetch / IR load / decode / execute / writeback for the datapath.
module ctrl_fsm #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PROG_WORDS = 256,
  parameter bit          BOOT_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             boot_valid,
  input  logic [WIDTH-1:0] boot_data,
  input  logic             boot_last,
  output logic             boot_ready,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             regfile_wren,
  output logic             ir_wren,
  output logic             pc_inc,
  output logic             mem_wren,
  output logic             ram_raddr_31_20,
  output logic [1:0]       regfile_sel_from_alu_mem_pcp4,
  output logic             jumping,
  output logic             retire,
  output logic             halted
);

  localparam int unsigned CNT_W = $clog2(PROG_WORDS) + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_PCP4 = 2'd2;

  typedef enum logic [3:0] {
    S_BOOT,
    S_BOOT_END,
    S_FETCH,
    S_LOAD_IR,
    S_DECODE,
    S_ALU_WB,
    S_LD_ADDR,
    S_LD_WB,
    S_ST,
    S_JUMP,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_retire;
  logic             w_accept;
  logic             w_known_op;
  logic             w_nop_retire;

  logic             w_boot_ready;
  logic             w_regfile_wren;
  logic             w_ir_wren;
  logic             w_pc_inc;
  logic             w_mem_wren;
  logic             w_ram_raddr_31_20;
  logic [1:0]       w_sel;
  logic             w_jumping;
  logic             w_retire;
  logic             w_halted;

  // Next-state logic; boot handshakes only count while the FSM sits in BOOT.
  always_comb begin
    w_next     = r_state;
    w_accept   = boot_valid && boot_ready && (r_state == S_BOOT);
    w_known_op = 1'b1;
    case (r_state)
      S_BOOT: begin
        if (w_accept && (boot_last || (r_cnt == CNT_W'(PROG_WORDS - 1))))
          w_next = S_BOOT_END;
      end
      S_BOOT_END: w_next = S_FETCH;
      S_FETCH:    w_next = S_LOAD_IR;
      S_LOAD_IR:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM: w_next = S_ALU_WB;
          OPC_LOAD:           w_next = S_LD_ADDR;
          OPC_STORE:          w_next = S_ST;
          OPC_JAL, OPC_JALR:  w_next = S_JUMP;
          OPC_SYSTEM:         w_next = S_HALT;
          default: begin
            w_next     = S_FETCH;
            w_known_op = 1'b0;
          end
        endcase
      end
      S_LD_ADDR: w_next = S_LD_WB;
      S_ALU_WB, S_LD_WB, S_ST, S_JUMP: w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end

  // Output decode of the state being entered, so the registered outputs track r_state.
  always_comb begin
    w_boot_ready      = 1'b0;
    w_regfile_wren    = 1'b0;
    w_ir_wren         = 1'b0;
    w_pc_inc          = 1'b0;
    w_mem_wren        = 1'b0;
    w_ram_raddr_31_20 = 1'b0;
    w_sel             = SEL_ALU;
    w_jumping         = 1'b0;
    w_retire          = 1'b0;
    w_halted          = 1'b0;
    case (w_next)
      S_BOOT:    w_boot_ready = 1'b1;
      S_LOAD_IR: begin
        w_ir_wren = 1'b1;
        w_pc_inc  = 1'b1;
      end
      S_ALU_WB: begin
        w_regfile_wren = 1'b1;
        w_sel          = SEL_ALU;
        w_retire       = 1'b1;
      end
      S_LD_ADDR: w_ram_raddr_31_20 = 1'b1;
      S_LD_WB: begin
        w_ram_raddr_31_20 = 1'b1;
        w_regfile_wren    = 1'b1;
        w_sel             = SEL_MEM;
        w_retire          = 1'b1;
      end
      S_ST: begin
        w_ram_raddr_31_20 = 1'b1;
        w_mem_wren        = 1'b1;
        w_retire          = 1'b1;
      end
      S_JUMP: begin
        w_regfile_wren = 1'b1;
        w_sel          = SEL_PCP4;
        w_pc_inc       = 1'b1;
        w_jumping      = 1'b1;
        w_retire       = 1'b1;
      end
      S_HALT:  w_halted = 1'b1;
      default: w_boot_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                       <= BOOT_EN ? S_BOOT : S_FETCH;
      r_cnt                         <= '0;
      r_retire                      <= 1'b0;
      boot_ready                    <= 1'b0;
      flash_en                      <= 1'b0;
      flash_addr                    <= '0;
      flash_data                    <= '0;
      regfile_wren                  <= 1'b0;
      ir_wren                       <= 1'b0;
      pc_inc                        <= 1'b0;
      mem_wren                      <= 1'b0;
      ram_raddr_31_20               <= 1'b0;
      regfile_sel_from_alu_mem_pcp4 <= SEL_ALU;
      jumping                       <= 1'b0;
      halted                        <= 1'b0;
    end else begin
      r_state                       <= w_next;
      r_retire                      <= w_retire;
      boot_ready                    <= w_boot_ready;
      regfile_wren                  <= w_regfile_wren;
      ir_wren                       <= w_ir_wren;
      pc_inc                        <= w_pc_inc;
      mem_wren                      <= w_mem_wren;
      ram_raddr_31_20               <= w_ram_raddr_31_20;
      regfile_sel_from_alu_mem_pcp4 <= w_sel;
      jumping                       <= w_jumping;
      halted                        <= w_halted;
      flash_en                      <= w_accept;
      flash_data                    <= w_accept ? boot_data : '0;
      flash_addr                    <= w_accept ? WIDTH'({r_cnt, 2'b00}) : '0;
      if (w_accept)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Unknown opcodes retire in DECODE itself, which needs the live opcode.
  assign w_nop_retire = (r_state == S_DECODE) && !w_known_op && !rst;
  assign retire       = r_retire || w_nop_retire;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: a small datapath model executes the booted
// program while flash writes and retirements are checked against queued expectations.
`timescale 1ns/1ps
module tb_ctrl_fsm;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned PW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       opcode;
  logic             boot_valid = 1'b0;
  logic [WIDTH-1:0] boot_data = '0;
  logic             boot_last = 1'b0;
  logic             boot_ready, flash_en, regfile_wren, ir_wren, pc_inc, mem_wren;
  logic             ram_raddr_31_20, jumping, retire, halted;
  logic [WIDTH-1:0] flash_addr, flash_data;
  logic [1:0]       sel;

  always #5 clk = ~clk;

  ctrl_fsm #(.WIDTH(WIDTH), .PROG_WORDS(PW), .BOOT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
    .boot_ready(boot_ready), .flash_en(flash_en), .flash_addr(flash_addr),
    .flash_data(flash_data), .regfile_wren(regfile_wren), .ir_wren(ir_wren),
    .pc_inc(pc_inc), .mem_wren(mem_wren), .ram_raddr_31_20(ram_raddr_31_20),
    .regfile_sel_from_alu_mem_pcp4(sel), .jumping(jumping), .retire(retire),
    .halted(halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Datapath model: memory, IR, PC and register file driven by the controls.
  logic [31:0] mem [16];
  logic [31:0] rf  [32];
  logic [31:0] pc = '0;
  logic [31:0] ir = '0;
  logic [31:0] iimm, jimm;
  assign opcode = ir[6:0];
  assign iimm   = {{20{ir[31]}}, ir[31:20]};
  assign jimm   = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  always @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (flash_en) mem[flash_addr[5:2]] <= flash_data;
      if (ir_wren) ir <= mem[pc[5:2]];
      if (pc_inc) pc <= jumping ? pc - 32'd4 + jimm : pc + 32'd4;
      if (regfile_wren && ir[11:7] != 5'd0) begin
        case (sel)
          2'd0:    rf[ir[11:7]] <= rf[ir[19:15]] + iimm;
          2'd1:    rf[ir[11:7]] <= mem[ir[25:22]];
          default: rf[ir[11:7]] <= pc;
        endcase
      end
    end
  end

  typedef struct {
    int         cpi;
    logic [6:0] sig;   // {regfile_wren, mem_wren, pc_inc, jumping, sel, ram_raddr_31_20}
    int         ra;
  } ret_t;

  ret_t        ret_q[$];
  logic [63:0] flash_q[$];
  int cyc = 0;
  int ir_cyc = 0, ra_cnt = 0, flash_cnt = 0, first_ir = -1, halt_cyc = -1;
  int last_acc = 0, boot_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, pops expectations as outputs appear.
  always @(negedge clk) begin
    if (rst) begin
      ret_q.delete();
      flash_q.delete();
      flash_cnt = 0;
      first_ir  = -1;
      halt_cyc  = -1;
      ra_cnt    = 0;
    end else begin
      ret_t        r;
      logic [63:0] f;
      check_eq("excl_wren", 32'($countones({regfile_wren, mem_wren, ir_wren, flash_en}) <= 1), 32'd1);
      if (ir_wren) begin
        ir_cyc = cyc;
        ra_cnt = 0;
        if (first_ir < 0) first_ir = cyc;
      end
      if (ram_raddr_31_20) ra_cnt++;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (flash_en) begin
        flash_cnt++;
        check_eq("flash_pending", 32'(flash_q.size() != 0), 32'd1);
        if (flash_q.size() != 0) begin
          f = flash_q.pop_front();
          check_eq("flash_addr", flash_addr, f[63:32]);
          check_eq("flash_data", flash_data, f[31:0]);
        end
      end
      if (retire) begin
        check_eq("retire_pending", 32'(ret_q.size() != 0), 32'd1);
        if (ret_q.size() != 0) begin
          r = ret_q.pop_front();
          check_eq("cpi", 32'(cyc - ir_cyc + 2), 32'(r.cpi));
          check_eq("retire_ctrl",
                   32'({regfile_wren, mem_wren, pc_inc, jumping, sel, ram_raddr_31_20}),
                   32'(r.sig));
          check_eq("raddr_cycles", 32'(ra_cnt), 32'(r.ra));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    boot_valid = 1'b0;
    boot_last  = 1'b0;
    repeat (n) tick();
    rst      = 1'b0;
    boot_idx = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input int gap);
    int n = 0;
    repeat (gap) tick();
    boot_valid = 1'b1;
    boot_data  = d;
    boot_last  = last;
    while (!boot_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("boot_ready", 32'(boot_ready), 32'd1);
    if (boot_ready) flash_q.push_back({32'(boot_idx * 4), d});
    boot_idx++;
    tick();
    last_acc   = cyc;
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic push_ret(input int cpi, input logic [6:0] sig, input int ra);
    ret_t r;
    r.cpi = cpi;
    r.sig = sig;
    r.ra  = ra;
    ret_q.push_back(r);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check_eq("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic wait_first_ir(input int budget);
    int n = 0;
    while (first_ir < 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("first_fetch", 32'(first_ir), 32'(last_acc + 2));
  endtask

  logic any_out;
  assign any_out = |{boot_ready, flash_en, flash_addr, flash_data, regfile_wren, ir_wren,
                     pc_inc, mem_wren, ram_raddr_31_20, sel, jumping, retire, halted};

  localparam logic [6:0] SIG_ALU  = 7'b1000_00_0;
  localparam logic [6:0] SIG_LD   = 7'b1000_01_1;
  localparam logic [6:0] SIG_ST   = 7'b0100_00_1;
  localparam logic [6:0] SIG_JMP  = 7'b1011_10_0;
  localparam logic [6:0] SIG_NOP  = 7'b0000_00_0;

  initial begin
    int hcnt;
    int n;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_eq("reset_outs", 32'(any_out), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("boot_ready_after_rst", 32'(boot_ready), 32'd1);

    // Boot three words with a stall, then run the ALU program to HALT
    do_reset(2);
    push_ret(4, SIG_ALU, 0);
    push_ret(4, SIG_ALU, 0);
    send(32'h00500093, 1'b0, 0);
    send(32'h00108113, 1'b0, 2);
    send(32'h00000073, 1'b1, 0);
    wait_first_ir(10);
    wait_halt(60);
    check_eq("halt_cycle", 32'(halt_cyc), 32'(first_ir - 1 + 11));
    hcnt = 0;
    boot_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted) hcnt++;
    end
    boot_valid = 1'b0;
    check_eq("halt_hold", 32'(hcnt), 32'd20);
    check_eq("x1", rf[1], 32'd5);
    check_eq("x2", rf[2], 32'd6);
    check_eq("ret_left_alu", 32'(ret_q.size()), 32'd0);
    check_eq("flash_count3", 32'(flash_cnt), 32'd3);

    // LOAD then STORE
    do_reset(2);
    push_ret(5, SIG_LD, 2);
    push_ret(4, SIG_ST, 1);
    send(32'h00C02183, 1'b0, 0);
    send(32'h00302823, 1'b0, 0);
    send(32'h00000073, 1'b0, 1);
    send(32'hDEADBEEF, 1'b1, 0);
    wait_halt(60);
    check_eq("x3_load", rf[3], 32'hDEADBEEF);
    check_eq("ret_left_ldst", 32'(ret_q.size()), 32'd0);

    // Reset held 3 cycles from inside LD_WB
    do_reset(2);
    push_ret(5, SIG_LD, 2);
    push_ret(4, SIG_ST, 1);
    send(32'h00C02183, 1'b0, 0);
    send(32'h00302823, 1'b0, 0);
    send(32'h00000073, 1'b0, 0);
    send(32'hDEADBEEF, 1'b1, 0);
    n = 0;
    while (!(regfile_wren && sel == 2'd1) && n < 40) begin
      tick();
      n++;
    end
    check_eq("ld_wb_seen", 32'(regfile_wren && sel == 2'd1), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rst_outs_1", 32'(any_out), 32'd0);
    tick();
    tick();
    check_eq("rst_outs_3", 32'(any_out), 32'd0);
    check_eq("rst_flush", 32'(ret_q.size()), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_boot_ready", 32'(boot_ready), 32'd1);

    // Boot cap: no boot_last, stalls between words, extra word offered afterwards
    do_reset(2);
    send(32'h00000073, 1'b0, 0);
    send(32'h00000073, 1'b0, 3);
    send(32'h00000073, 1'b0, 0);
    send(32'h00000073, 1'b0, 1);
    boot_valid = 1'b1;
    boot_data  = 32'h0000BAD0;
    wait_first_ir(10);
    boot_valid = 1'b0;
    check_eq("flash_count_cap", 32'(flash_cnt), 32'(PW));

    // JAL skips a SYSTEM word, then an unknown opcode retires as a NOP
    do_reset(2);
    push_ret(4, SIG_JMP, 0);
    push_ret(3, SIG_NOP, 0);
    send(32'h008000EF, 1'b0, 0);
    send(32'h00000073, 1'b0, 0);
    send(32'h123452B7, 1'b0, 0);
    send(32'h00000073, 1'b1, 0);
    wait_halt(60);
    check_eq("x1_link", rf[1], 32'd4);
    check_eq("ret_left_jmp", 32'(ret_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
